flow_csr_axil_slave: RTL

AXI4-Lite responder that terminates CSR traffic for the flow-classification path. Exposes the 128-bit flow key from the flow key generator as four read-only 32-bit words. Provides a write-only data port that streams words into the flow-table hash BRAM through an auto-incrementing pointer. Sits between the PS AXI-Lite interconnect and the flow_key_gen / flow_table logic in the PL.

---
 rtl/flow_csr_axil_slave.sv | 354 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/flow_csr_axil_slave.sv
// flow_csr_axil_slave
// AXI4-Lite CSR responder for the flow-classification path. It exposes the
// 128-bit flow key as four read-only words and streams written words into the
// flow-table hash BRAM through an auto-incrementing pointer.
// Optional build macro: FLOW_CSR_SNAPSHOT_EN. When it is defined, key reads are
// served from a shadow and snapshot pair, so a four-word read is coherent.
module flow_csr_axil_slave #(
  parameter int unsigned BRAM_AW   = 10,
  parameter logic [31:0] BASE_MASK = 32'h0000_001F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [127:0]       flow_key,
  input  logic               flow_key_vld,
  input  logic [31:0]        s_axi_awaddr,
  input  logic               s_axi_awvalid,
  output logic               s_axi_awready,
  input  logic [31:0]        s_axi_wdata,
  input  logic [3:0]         s_axi_wstrb,
  input  logic               s_axi_wvalid,
  output logic               s_axi_wready,
  output logic [1:0]         s_axi_bresp,
  output logic               s_axi_bvalid,
  input  logic               s_axi_bready,
  input  logic [31:0]        s_axi_araddr,
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  output logic [31:0]        s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  output logic               bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [31:0]        bram_wdata
);

  localparam logic [31:0] OFF_KEY_32    = 32'h0000_0000;
  localparam logic [31:0] OFF_KEY_64    = 32'h0000_0004;
  localparam logic [31:0] OFF_KEY_96    = 32'h0000_0008;
  localparam logic [31:0] OFF_KEY_128   = 32'h0000_000C;
  localparam logic [31:0] OFF_BRAM_PTR  = 32'h0000_0010;
  localparam logic [31:0] OFF_BRAM_DATA = 32'h0000_0014;
  localparam logic [31:0] OFF_STATUS    = 32'h0000_0018;
  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [15:0] CNT_MAX       = 16'hFFFF;
  localparam logic [BRAM_AW-1:0] PTR_ONE = {{(BRAM_AW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // ---------------- write side ----------------
  w_state_t             w_state_r, w_state_nxt_s;
  logic                 awready_r, awready_nxt_s;
  logic                 wready_r, wready_nxt_s;
  logic                 bvalid_r, bvalid_nxt_s;
  logic [1:0]           bresp_r, bresp_nxt_s;
  logic                 aw_held_r, aw_held_nxt_s;
  logic                 w_held_r, w_held_nxt_s;
  logic [31:0]          awaddr_r;
  logic [31:0]          wdata_r;
  logic [BRAM_AW-1:0]   ptr_r;
  logic [15:0]          count_r;
  logic                 bram_we_r;
  logic [BRAM_AW-1:0]   bram_addr_r;
  logic [31:0]          bram_wdata_r;

  logic                 aw_hs_s, w_hs_s, b_hs_s;
  logic [31:0]          wr_addr_s, wr_data_s, wr_off_s;
  logic                 wr_is_ptr_s, wr_is_data_s, wr_exec_s;

  // Byte enables are not honoured: every write is a full word.
  logic                 unused_s;
  assign unused_s = &{1'b0, s_axi_wstrb};

  assign aw_hs_s      = s_axi_awvalid & awready_r;
  assign w_hs_s       = s_axi_wvalid & wready_r;
  assign b_hs_s       = bvalid_r & s_axi_bready;
  // A channel captured in an earlier cycle wins over the live bus value.
  assign wr_addr_s    = aw_held_r ? awaddr_r : s_axi_awaddr;
  assign wr_data_s    = w_held_r ? wdata_r : s_axi_wdata;
  assign wr_off_s     = wr_addr_s & BASE_MASK;
  assign wr_is_ptr_s  = (wr_off_s == OFF_BRAM_PTR);
  assign wr_is_data_s = (wr_off_s == OFF_BRAM_DATA);

  // Write FSM next state: collect AW and W independently, execute when both are present.
  always_comb begin
    w_state_nxt_s = w_state_r;
    wr_exec_s     = 1'b0;
    awready_nxt_s = awready_r;
    wready_nxt_s  = wready_r;
    bvalid_nxt_s  = bvalid_r;
    bresp_nxt_s   = bresp_r;
    aw_held_nxt_s = aw_held_r;
    w_held_nxt_s  = w_held_r;
    case (w_state_r)
      W_IDLE: begin
        if ((aw_held_r | aw_hs_s) & (w_held_r | w_hs_s)) begin
          wr_exec_s     = 1'b1;
          w_state_nxt_s = W_RESP;
          awready_nxt_s = 1'b0;
          wready_nxt_s  = 1'b0;
          bvalid_nxt_s  = 1'b1;
          bresp_nxt_s   = (wr_is_ptr_s | wr_is_data_s) ? RESP_OKAY : RESP_SLVERR;
          aw_held_nxt_s = 1'b0;
          w_held_nxt_s  = 1'b0;
        end else begin
          if (aw_hs_s) begin
            aw_held_nxt_s = 1'b1;
            awready_nxt_s = 1'b0;
          end else begin
            aw_held_nxt_s = aw_held_r;
            awready_nxt_s = awready_r;
          end
          if (w_hs_s) begin
            w_held_nxt_s = 1'b1;
            wready_nxt_s = 1'b0;
          end else begin
            w_held_nxt_s = w_held_r;
            wready_nxt_s = wready_r;
          end
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          w_state_nxt_s = W_IDLE;
          awready_nxt_s = 1'b1;
          wready_nxt_s  = 1'b1;
          bvalid_nxt_s  = 1'b0;
        end else begin
          w_state_nxt_s = W_RESP;
          awready_nxt_s = 1'b0;
          wready_nxt_s  = 1'b0;
          bvalid_nxt_s  = 1'b1;
        end
      end
      default: begin
        w_state_nxt_s = W_IDLE;
        awready_nxt_s = 1'b1;
        wready_nxt_s  = 1'b1;
        bvalid_nxt_s  = 1'b0;
        bresp_nxt_s   = RESP_OKAY;
        aw_held_nxt_s = 1'b0;
        w_held_nxt_s  = 1'b0;
      end
    endcase
  end

  // Write FSM state and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b1;
      wready_r  <= 1'b1;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_nxt_s;
      awready_r <= awready_nxt_s;
      wready_r  <= wready_nxt_s;
      bvalid_r  <= bvalid_nxt_s;
      bresp_r   <= bresp_nxt_s;
      aw_held_r <= aw_held_nxt_s;
      w_held_r  <= w_held_nxt_s;
    end
  end

  // Hold the address and data of a channel that arrives ahead of its partner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awaddr_r <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
    end else begin
      if (aw_hs_s) awaddr_r <= s_axi_awaddr;
      if (w_hs_s)  wdata_r  <= s_axi_wdata;
    end
  end

  // Execute the write: BRAM pulse, pointer load or advance, and the saturating count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r        <= {BRAM_AW{1'b0}};
      count_r      <= 16'h0000;
      bram_we_r    <= 1'b0;
      bram_addr_r  <= {BRAM_AW{1'b0}};
      bram_wdata_r <= 32'h0000_0000;
    end else begin
      bram_we_r <= wr_exec_s & wr_is_data_s;
      if (wr_exec_s & wr_is_data_s) begin
        bram_addr_r  <= ptr_r;
        bram_wdata_r <= wr_data_s;
        ptr_r        <= ptr_r + PTR_ONE;
        if (count_r != CNT_MAX) count_r <= count_r + 16'h0001;
      end else if (wr_exec_s & wr_is_ptr_s) begin
        ptr_r <= wr_data_s[BRAM_AW-1:0];
      end
    end
  end

  // ---------------- read side ----------------
  r_state_t    r_state_r, r_state_nxt_s;
  logic        arready_r, arready_nxt_s;
  logic        rvalid_r, rvalid_nxt_s;
  logic [31:0] rdata_r, rdata_nxt_s;
  logic [1:0]  rresp_r, rresp_nxt_s;
  logic        flag_r;

  logic        ar_hs_s, r_hs_s, rd_key0_s;
  logic [31:0] rd_off_s, rd_data_s;
  logic [1:0]  rd_resp_s;
  logic [31:0] key_w0_s, key_w1_s, key_w2_s, key_w3_s;

  assign ar_hs_s   = s_axi_arvalid & arready_r;
  assign r_hs_s    = rvalid_r & s_axi_rready;
  assign rd_off_s  = s_axi_araddr & BASE_MASK;
  assign rd_key0_s = ar_hs_s & (rd_off_s == OFF_KEY_32);

`ifdef FLOW_CSR_SNAPSHOT_EN
  logic [127:0] shadow_r;
  logic [95:0]  snap_r;

  // Shadow follows every new key from the generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= 128'h0;
    end else if (flow_key_vld) begin
      shadow_r <= flow_key;
    end
  end

  // Reading word 0 freezes the upper words for the rest of the sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r <= 96'h0;
    end else if (rd_key0_s) begin
      snap_r <= shadow_r[127:32];
    end
  end

  assign key_w0_s = shadow_r[31:0];
  assign key_w1_s = snap_r[31:0];
  assign key_w2_s = snap_r[63:32];
  assign key_w3_s = snap_r[95:64];
`else
  assign key_w0_s = flow_key[31:0];
  assign key_w1_s = flow_key[63:32];
  assign key_w2_s = flow_key[95:64];
  assign key_w3_s = flow_key[127:96];
`endif

  // Read address decode; unmapped offsets answer zero with SLVERR.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_resp_s = RESP_OKAY;
    case (rd_off_s)
      OFF_KEY_32:    rd_data_s = key_w0_s;
      OFF_KEY_64:    rd_data_s = key_w1_s;
      OFF_KEY_96:    rd_data_s = key_w2_s;
      OFF_KEY_128:   rd_data_s = key_w3_s;
      OFF_BRAM_PTR:  rd_data_s = {{(32-BRAM_AW){1'b0}}, ptr_r};
      OFF_BRAM_DATA: rd_data_s = 32'h0000_0000;
      OFF_STATUS:    rd_data_s = {15'h0000, flag_r, count_r};
      default: begin
        rd_data_s = 32'h0000_0000;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // Read FSM next state: accept in R_IDLE, hold the response until rready.
  always_comb begin
    r_state_nxt_s = r_state_r;
    arready_nxt_s = arready_r;
    rvalid_nxt_s  = rvalid_r;
    rdata_nxt_s   = rdata_r;
    rresp_nxt_s   = rresp_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_nxt_s = R_DATA;
          arready_nxt_s = 1'b0;
          rvalid_nxt_s  = 1'b1;
          rdata_nxt_s   = rd_data_s;
          rresp_nxt_s   = rd_resp_s;
        end else begin
          r_state_nxt_s = R_IDLE;
          arready_nxt_s = 1'b1;
          rvalid_nxt_s  = 1'b0;
        end
      end
      R_DATA: begin
        if (r_hs_s) begin
          r_state_nxt_s = R_IDLE;
          arready_nxt_s = 1'b1;
          rvalid_nxt_s  = 1'b0;
        end else begin
          r_state_nxt_s = R_DATA;
          arready_nxt_s = 1'b0;
          rvalid_nxt_s  = 1'b1;
        end
      end
      default: begin
        r_state_nxt_s = R_IDLE;
        arready_nxt_s = 1'b1;
        rvalid_nxt_s  = 1'b0;
        rdata_nxt_s   = 32'h0000_0000;
        rresp_nxt_s   = RESP_OKAY;
      end
    endcase
  end

  // Read FSM state and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0000_0000;
      rresp_r   <= RESP_OKAY;
    end else begin
      r_state_r <= r_state_nxt_s;
      arready_r <= arready_nxt_s;
      rvalid_r  <= rvalid_nxt_s;
      rdata_r   <= rdata_nxt_s;
      rresp_r   <= rresp_nxt_s;
    end
  end

  // Key-valid flag: a new key sets it, a read of word 0 clears it; setting wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_r <= 1'b0;
    end else if (flow_key_vld) begin
      flag_r <= 1'b1;
    end else if (rd_key0_s) begin
      flag_r <= 1'b0;
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign bram_we       = bram_we_r;
  assign bram_addr     = bram_addr_r;
  assign bram_wdata    = bram_wdata_r;

endmodule
